// File: rtl/dispatch_pkg.sv
// Shared types and constants for the decode-to-dispatch queue.
// The packet layout is fixed here, so WIDTH/ROB/NUM_RS follow it.
package dispatch_pkg;

  localparam int DQ_WIDTH  = 31;
  localparam int DQ_ROB    = 2;
  localparam int DQ_NUM_RS = 4;
  localparam int DQ_RS_W   = $clog2(DQ_NUM_RS);

  localparam logic [3:0] RESET_ALU_CTRL = 4'b1111;
  localparam logic [2:0] RESET_FUNCT3   = 3'b111;

  typedef struct packed {
    logic [DQ_WIDTH:0]   pc;
    logic [DQ_WIDTH:0]   operand1;
    logic [DQ_WIDTH:0]   operand2;
    logic [DQ_WIDTH:0]   immExt;
    logic [3:0]          ALUControl;
    logic [DQ_RS_W-1:0]  RSstation;
    logic [DQ_ROB:0]     rob1;
    logic [DQ_ROB:0]     rob2;
    logic                busy1;
    logic                busy2;
    logic [DQ_ROB:0]     robInstr;
    logic [4:0]          destReg;
    logic                regWrite;
    logic                isJAL;
    logic                isJALR;
    logic                useImm;
    logic [2:0]          branchFunct3;
    logic [DQ_WIDTH:0]   predictPC;
    logic [1:0]          state;
  } decodePacket_t;

  localparam decodePacket_t BUBBLE_PKT = '{
    ALUControl:   RESET_ALU_CTRL,
    isJAL:        1'b1,
    isJALR:       1'b1,
    branchFunct3: RESET_FUNCT3,
    default:      '0
  };

endpackage

// File: rtl/dispatch_if.sv
// Decode-side and dispatch-side signals of the dispatch queue.
// slave = the queue, master = decode/RS/ROB/CDB environment.
interface dispatch_if #(
  parameter int WIDTH  = dispatch_pkg::DQ_WIDTH,
  parameter int ROB    = dispatch_pkg::DQ_ROB,
  parameter int DEPTH  = 4,
  parameter int NUM_RS = dispatch_pkg::DQ_NUM_RS
);
  import dispatch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic              inValid;
  logic              inReady;
  decodePacket_t     inPacket;
  logic [NUM_RS-1:0] stationFull;
  logic              robFull;
  logic              cdbValid;
  logic [ROB:0]      cdbROB;
  logic [WIDTH:0]    cdbResult;
  logic              outValid;
  logic              outFire;
  decodePacket_t     outPacket;
  logic              headStall;
  logic [CW-1:0]     count;

  modport master (
    output inValid, inPacket, stationFull, robFull,
    output cdbValid, cdbROB, cdbResult,
    input  inReady, outValid, outFire, outPacket,
    input  headStall, count
  );

  modport slave (
    input  inValid, inPacket, stationFull, robFull,
    input  cdbValid, cdbROB, cdbResult,
    output inReady, outValid, outFire, outPacket,
    output headStall, count
  );

endinterface

// File: rtl/dispatch_queue_cdb_wakeup.sv
// Per-packet CDB tag compare: a matching busy operand takes the
// broadcast value and clears its busy flag.
module cdb_wakeup
  import dispatch_pkg::*;
(
  input  decodePacket_t       pkt,
  input  logic                cdbValid,
  input  logic [DQ_ROB:0]     cdbROB,
  input  logic [DQ_WIDTH:0]   cdbResult,
  output decodePacket_t       woken
);

  logic hit1;
  logic hit2;

  assign hit1 = cdbValid & pkt.busy1 & (pkt.rob1 == cdbROB);
  assign hit2 = cdbValid & pkt.busy2 & (pkt.rob2 == cdbROB);

  // replace each waiting operand independently
  always_comb begin
    woken = pkt;
    if (hit1) begin
      woken.operand1 = cdbResult;
      woken.busy1    = 1'b0;
    end
    if (hit2) begin
      woken.operand2 = cdbResult;
      woken.busy2    = 1'b0;
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// In-order decode/dispatch buffer with CDB snooping,
// per-station dispatch stall and flush-on-redirect.
module dispatch_queue
  import dispatch_pkg::*;
#(
  parameter int WIDTH  = DQ_WIDTH,
  parameter int ROB    = DQ_ROB,
  parameter int DEPTH  = 4,
  parameter int NUM_RS = DQ_NUM_RS
) (
  input logic       clk,
  input logic       globalResetN,
  input logic       flush,
  dispatch_if.slave q
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  decodePacket_t     mem      [DEPTH];
  decodePacket_t     memWoken [DEPTH];
  decodePacket_t     inWoken;
  decodePacket_t     headWoken;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     cnt;
  logic [ROB:0]      tag;
  logic [WIDTH:0]    result;
  logic [NUM_RS-1:0] stFull;
  logic              empty;
  logic              full;
  logic              valid;
  logic              enq;
  logic              fire;

  assign tag    = q.cdbROB;
  assign result = q.cdbResult;
  assign stFull = q.stationFull;

  for (genvar i = 0; i < DEPTH; i++) begin : g_wake
    cdb_wakeup u_wake (
      .pkt       (mem[i]),
      .cdbValid  (q.cdbValid),
      .cdbROB    (tag),
      .cdbResult (result),
      .woken     (memWoken[i])
    );
  end

  cdb_wakeup u_wake_in (
    .pkt       (q.inPacket),
    .cdbValid  (q.cdbValid),
    .cdbROB    (tag),
    .cdbResult (result),
    .woken     (inWoken)
  );

  cdb_wakeup u_wake_head (
    .pkt       (mem[head]),
    .cdbValid  (q.cdbValid),
    .cdbROB    (tag),
    .cdbResult (result),
    .woken     (headWoken)
  );

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign valid = !empty & !flush;
  assign enq   = q.inValid & !full & !flush;

  // empty queue presents the bubble encoding
  always_comb begin
    q.outPacket = BUBBLE_PKT;
    if (!empty) q.outPacket = headWoken;
  end

  assign fire = valid & !q.robFull
              & !stFull[q.outPacket.RSstation];

  assign q.inReady   = !full;
  assign q.outValid  = valid;
  assign q.outFire   = fire;
  assign q.headStall = valid & !fire;
  assign q.count     = cnt;

  // storage: every entry snoops the CDB each cycle
  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= memWoken[i];
      if (enq) mem[tail] <= inWoken;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (enq)  tail <= tail + 1'b1;
      if (fire) head <= head + 1'b1;
      unique case ({enq, fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: vector table,
// directed corner sequences and a queue-based random model.
module tb_dispatch_queue;
  import dispatch_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  dispatch_if #(.DEPTH(DEPTH)) bus ();

  dispatch_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .globalResetN (rst_n),
    .flush        (flush),
    .q            (bus)
  );

  typedef struct {
    logic inV;
    logic robF;
    int   pc;
    int   eCnt;
    logic eRdy;
    logic eOv;
    logic eFire;
    int   ePc;
  } vec_t;

  vec_t          tbl [10];
  decodePacket_t mq [$];
  int            total = 0;
  int            bad = 0;
  logic          expFire;

  task automatic chk1(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chkp(string name, decodePacket_t act, decodePacket_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic decodePacket_t bubbleRef();
    decodePacket_t p = '0;
    p.ALUControl   = 4'b1111;
    p.isJAL        = 1'b1;
    p.isJALR       = 1'b1;
    p.branchFunct3 = 3'b111;
    return p;
  endfunction

  function automatic decodePacket_t mk(int pcv, logic [DQ_RS_W-1:0] rs,
                                       logic b1, logic [2:0] r1,
                                       logic b2, logic [2:0] r2,
                                       logic [31:0] op1);
    decodePacket_t p = '0;
    p.pc        = pcv;
    p.RSstation = rs;
    p.busy1     = b1;
    p.rob1      = r1;
    p.busy2     = b2;
    p.rob2      = r2;
    p.operand1  = op1;
    p.operand2  = 32'h1000 + pcv;
    return p;
  endfunction

  function automatic decodePacket_t rnd();
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
    return b[$bits(decodePacket_t)-1:0];
  endfunction

  // operand capture from the current broadcast
  function automatic decodePacket_t wake(decodePacket_t p);
    decodePacket_t r = p;
    if (bus.cdbValid && p.busy1 && p.rob1 == bus.cdbROB) begin
      r.operand1 = bus.cdbResult;
      r.busy1    = 1'b0;
    end
    if (bus.cdbValid && p.busy2 && p.rob2 == bus.cdbROB) begin
      r.operand2 = bus.cdbResult;
      r.busy2    = 1'b0;
    end
    return r;
  endfunction

  task automatic idle();
    bus.inValid     = 1'b0;
    bus.inPacket    = '0;
    bus.stationFull = '0;
    bus.robFull     = 1'b0;
    bus.cdbValid    = 1'b0;
    bus.cdbROB      = '0;
    bus.cdbResult   = '0;
    flush           = 1'b0;
  endtask

  task automatic settle();
    decodePacket_t hd;
    logic ov;
    logic rdy;
    @(negedge clk);
    hd = bubbleRef();
    if (mq.size() != 0) hd = wake(mq[0]);
    ov  = (mq.size() != 0) && !flush;
    rdy = (mq.size() < DEPTH);
    expFire = ov && !bus.robFull && !bus.stationFull[hd.RSstation];
    chk1("count", 32'(bus.count), 32'(mq.size()));
    chk1("inReady", 32'(bus.inReady), 32'(rdy));
    chk1("outValid", 32'(bus.outValid), 32'(ov));
    chk1("outFire", 32'(bus.outFire), 32'(expFire));
    chk1("headStall", 32'(bus.headStall), 32'(ov && !expFire));
    if (!flush) chkp("outPacket", bus.outPacket, hd);
  endtask

  task automatic advance();
    decodePacket_t inp;
    logic enq;
    enq = bus.inValid && (mq.size() < DEPTH) && !flush;
    inp = wake(bus.inPacket);
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      if (expFire) void'(mq.pop_front());
      foreach (mq[i]) mq[i] = wake(mq[i]);
      if (enq) mq.push_back(inp);
    end
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hold;

    tbl[0] = '{1'b1, 1'b1, 100, 0, 1'b1, 1'b0, 1'b0, -1};
    tbl[1] = '{1'b1, 1'b1, 101, 1, 1'b1, 1'b1, 1'b0, 100};
    tbl[2] = '{1'b1, 1'b1, 102, 2, 1'b1, 1'b1, 1'b0, 100};
    tbl[3] = '{1'b1, 1'b1, 103, 3, 1'b1, 1'b1, 1'b0, 100};
    tbl[4] = '{1'b1, 1'b1, 200, 4, 1'b0, 1'b1, 1'b0, 100};
    tbl[5] = '{1'b0, 1'b0, 0,   4, 1'b0, 1'b1, 1'b1, 100};
    tbl[6] = '{1'b0, 1'b0, 0,   3, 1'b1, 1'b1, 1'b1, 101};
    tbl[7] = '{1'b0, 1'b0, 0,   2, 1'b1, 1'b1, 1'b1, 102};
    tbl[8] = '{1'b0, 1'b0, 0,   1, 1'b1, 1'b1, 1'b1, 103};
    tbl[9] = '{1'b0, 1'b0, 0,   0, 1'b1, 1'b0, 1'b0, -1};

    idle();
    #3;
    chk1("rst_count", 32'(bus.count), 0);
    chk1("rst_inReady", 32'(bus.inReady), 1);
    chk1("rst_outValid", 32'(bus.outValid), 0);
    chk1("rst_outFire", 32'(bus.outFire), 0);
    chk1("rst_headStall", 32'(bus.headStall), 0);
    chkp("rst_outPacket", bus.outPacket, bubbleRef());
    #4;
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      bus.inValid  = tbl[k].inV;
      bus.robFull  = tbl[k].robF;
      bus.inPacket = mk(tbl[k].pc, '0, 1'b0, '0, 1'b0, '0, 32'h0);
      settle();
      chk1("tbl_count", 32'(bus.count), tbl[k].eCnt);
      chk1("tbl_inReady", 32'(bus.inReady), 32'(tbl[k].eRdy));
      chk1("tbl_outValid", 32'(bus.outValid), 32'(tbl[k].eOv));
      chk1("tbl_outFire", 32'(bus.outFire), 32'(tbl[k].eFire));
      if (tbl[k].ePc >= 0)
        chk1("tbl_pc", bus.outPacket.pc, tbl[k].ePc);
      advance();
    end

    // per-channel stall keeps younger packets behind the head
    idle();
    bus.stationFull = 4'b0100;
    bus.inValid = 1'b1;
    bus.inPacket = mk(300, 2'd2, 1'b0, '0, 1'b0, '0, 32'h0);
    cycle();
    bus.inPacket = mk(301, 2'd0, 1'b0, '0, 1'b0, '0, 32'h0);
    cycle();
    bus.inValid = 1'b0;
    settle();
    chk1("stall_headStall", 32'(bus.headStall), 1);
    chk1("stall_outFire", 32'(bus.outFire), 0);
    advance();
    bus.stationFull = 4'b0000;
    settle();
    chk1("stall_rel_fire", 32'(bus.outFire), 1);
    chk1("stall_rel_pc", bus.outPacket.pc, 300);
    advance();
    settle();
    chk1("stall_young_pc", bus.outPacket.pc, 301);
    advance();

    // CDB wakeup of a stored entry; non-matching tag untouched
    idle();
    bus.robFull = 1'b1;
    bus.inValid = 1'b1;
    bus.inPacket = mk(400, 2'd0, 1'b1, 3'd3, 1'b0, '0, 32'h0);
    cycle();
    bus.inPacket = mk(401, 2'd0, 1'b1, 3'd5, 1'b0, '0, 32'h55);
    cycle();
    bus.inValid = 1'b0;
    bus.cdbValid = 1'b1;
    bus.cdbROB = 3'd3;
    bus.cdbResult = 32'hDEADBEEF;
    cycle();
    bus.cdbValid = 1'b0;
    settle();
    chk1("wake_op1", bus.outPacket.operand1, 32'hDEADBEEF);
    chk1("wake_busy1", 32'(bus.outPacket.busy1), 0);
    advance();
    bus.robFull = 1'b0;
    cycle();
    bus.robFull = 1'b1;
    settle();
    chk1("nowake_pc", bus.outPacket.pc, 401);
    chk1("nowake_op1", bus.outPacket.operand1, 32'h55);
    chk1("nowake_busy1", 32'(bus.outPacket.busy1), 1);
    advance();
    bus.robFull = 1'b0;
    cycle();

    // same-cycle head bypass plus enqueue capture
    idle();
    bus.inValid = 1'b1;
    bus.inPacket = mk(500, 2'd0, 1'b1, 3'd1, 1'b0, '0, 32'h0);
    cycle();
    bus.inPacket = mk(501, 2'd0, 1'b1, 3'd1, 1'b1, 3'd1, 32'h0);
    bus.cdbValid = 1'b1;
    bus.cdbROB = 3'd1;
    bus.cdbResult = 32'd7;
    settle();
    chk1("byp_fire", 32'(bus.outFire), 1);
    chk1("byp_pc", bus.outPacket.pc, 500);
    chk1("byp_op1", bus.outPacket.operand1, 7);
    chk1("byp_busy1", 32'(bus.outPacket.busy1), 0);
    advance();
    idle();
    bus.robFull = 1'b1;
    settle();
    chk1("cap_pc", bus.outPacket.pc, 501);
    chk1("cap_op1", bus.outPacket.operand1, 7);
    chk1("cap_op2", bus.outPacket.operand2, 7);
    chk1("cap_busy", {30'd0, bus.outPacket.busy1, bus.outPacket.busy2}, 0);
    advance();
    bus.robFull = 1'b0;
    cycle();

    // flush with simultaneous enqueue and dispatch at count 3
    idle();
    bus.robFull = 1'b1;
    bus.inValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.inPacket = mk(600 + i, 2'd0, 1'b0, '0, 1'b0, '0, 32'h0);
      cycle();
    end
    bus.inPacket = mk(666, 2'd0, 1'b0, '0, 1'b0, '0, 32'h0);
    bus.robFull = 1'b0;
    flush = 1'b1;
    settle();
    chk1("flush_fire", 32'(bus.outFire), 0);
    chk1("flush_ov", 32'(bus.outValid), 0);
    advance();
    idle();
    settle();
    chk1("post_flush_count", 32'(bus.count), 0);
    chk1("post_flush_ov", 32'(bus.outValid), 0);
    chk1("post_flush_rdy", 32'(bus.inReady), 1);
    advance();
    repeat (3) cycle();

    // wrap-around with enqueue/dispatch pairs
    idle();
    bus.inValid = 1'b1;
    bus.inPacket = mk(700, 2'd0, 1'b0, '0, 1'b0, '0, 32'h0);
    cycle();
    for (int i = 0; i < 10; i++) begin
      bus.inPacket = mk(701 + i, 2'd0, 1'b0, '0, 1'b0, '0, 32'h0);
      settle();
      chk1("wrap_pc", bus.outPacket.pc, 700 + i);
      advance();
    end
    bus.inValid = 1'b0;
    cycle();

    // randomized traffic against the queue model
    idle();
    hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        bus.inValid = ($urandom_range(0, 3) != 0);
        bus.inPacket = rnd();
      end
      bus.robFull = ($urandom_range(0, 3) == 0);
      bus.stationFull = 4'($urandom);
      bus.cdbValid = 1'($urandom_range(0, 1));
      bus.cdbROB = 3'($urandom);
      bus.cdbResult = $urandom;
      flush = ($urandom_range(0, 29) == 0);
      hold = bus.inValid && (mq.size() >= DEPTH);
      cycle();
    end

    // asynchronous reset mid-stream
    idle();
    bus.robFull = 1'b1;
    bus.inValid = 1'b1;
    bus.inPacket = mk(800, 2'd0, 1'b0, '0, 1'b0, '0, 32'h0);
    cycle();
    bus.inPacket = mk(801, 2'd0, 1'b0, '0, 1'b0, '0, 32'h0);
    cycle();
    bus.inValid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arst_ov", 32'(bus.outValid), 0);
    chk1("arst_count", 32'(bus.count), 0);
    chk1("arst_rdy", 32'(bus.inReady), 1);
    chkp("arst_pkt", bus.outPacket, bubbleRef());
    mq.delete();
    #2;
    rst_n = 1'b1;
    idle();
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
